// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder, one full-adder cell per cycle, LSB first.
// Define SERIAL_ADDER_SUB_EN to add a sub port selecting a + ~b + 1.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, s_q, s_d;
  logic c_q, c_d, cout_q, cout_d;
  logic sum_bit, maj, c_in;
  logic [WIDTH-1:0] b_in;
`ifdef SERIAL_ADDER_SUB_EN
  assign b_in = sub ? ~b : b;
  assign c_in = sub ? 1'b1 : cin;
`else
  assign b_in = b;
  assign c_in = cin;
`endif
  assign sum_bit = a_q[0] ^ b_q[0] ^ c_q;
  assign maj     = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);
  // a_q doubles as the sum shift register: operand bits leave at bit 0, sum bits enter at the MSB
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    s_d     = s_q;
    cout_d  = cout_q;
    case (state_q)
      IDLE: if (in_valid) begin
        a_d     = a;
        b_d     = b_in;
        c_d     = c_in;
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        a_d   = {sum_bit, a_q[WIDTH-1:1]};
        b_d   = b_q >> 1;
        c_d   = maj;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          s_d     = {sum_bit, a_q[WIDTH-1:1]};
          cout_d  = maj;
          state_d = DONE;
        end
      end
      default: state_d = out_ready ? IDLE : DONE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      s_q     <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
    end
  end
  assign in_ready  = state_q == IDLE;
  assign busy      = state_q == RUN;
  assign out_valid = state_q == DONE;
  assign s         = s_q;
  assign cout      = cout_q;
endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, meaning operand/sum width in bits; legal range 2..32.
REQ-002 SHALL provide port clk  input  1  single system clock; all state updates on rising edge.
REQ-003 SHALL provide port reset  input  1  asynchronous, active-low reset (reset=0 resets).
REQ-004 SHALL provide port in_valid  input  1  operand set a/b/cin presented.
REQ-005 SHALL provide port in_ready  output  1  block can accept operands.
REQ-006 SHALL provide port a  input  WIDTH  first operand.
REQ-007 SHALL provide port b  input  WIDTH  second operand.
REQ-008 SHALL provide port cin  input  1  carry-in.
REQ-009 SHALL provide port out_valid  output  1  s/cout hold a completed result.
REQ-010 SHALL provide port out_ready  input  1  consumer takes result.
REQ-011 SHALL provide port s  output  WIDTH  sum.
REQ-012 SHALL provide port cout  output  1  carry-out of bit WIDTH-1.
REQ-013 SHALL provide port busy  output  1  high while in RUN.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE; one full-adder cell plus carry flop computes one bit per cycle, LSB first.
REQ-015 SHALL drive in_ready=1 only in IDLE; out_valid=1 only in DONE; busy=1 only in RUN.
REQ-016 SHALL, on a clk edge with IDLE and in_valid=1, capture a, b, cin into internal registers, clear bit counter to 0, go to RUN.
REQ-017 SHALL, in RUN, each cycle compute bit k = a[k]^b[k]^c, update c = majority(a[k],b[k],c), write bit k into the sum shift register, increment k.
REQ-018 SHALL leave RUN for DONE on the edge processing bit WIDTH-1; out_valid rises exactly WIDTH cycles after the accepting edge.
REQ-019 SHALL hold s and cout stable in DONE until an edge with out_ready=1, then go to IDLE.
REQ-020 SHALL ignore a, b, cin, in_valid outside IDLE; changes to inputs after acceptance do not affect the result.
REQ-021 SHALL not accept new operands in the DONE->IDLE cycle; minimum initiation interval is WIDTH+2 cycles.
REQ-022 SHALL produce s = (a+b+cin) mod 2^WIDTH and cout = bit WIDTH of a+b+cin.
REQ-023 SHALL keep s/cout at previous result values in IDLE and RUN (s updated only through shift register visible in DONE).

Reset
REQ-024 SHALL, on reset=0 at any time including mid-RUN, immediately force state IDLE, counter 0, carry 0, s=0, cout=0, out_valid=0, busy=0, in_ready=1.
REQ-025 SHALL discard any in-flight operation on reset; first edge after reset release behaves as IDLE.

Configuration
REQ-026 SHALL, with SERIAL_ADDER_SUB_EN defined, add port sub  input  1, sampled with operands; sub=1 computes a + ~b + 1 (cin ignored), cout=1 meaning no borrow.
REQ-027 SHALL, without SERIAL_ADDER_SUB_EN, have no sub port and perform addition only.

Verification
REQ-028 SHALL cover: a=0x0F, b=0x01, cin=0 -> out_valid 8 cycles after accept, s=0x10, cout=0.
REQ-029 SHALL cover: a=0xFF, b=0x01, cin=1 -> s=0x01, cout=1 (wrap-around).
REQ-030 SHALL cover: result ready, out_ready held 0 for 5 cycles -> out_valid and s/cout stable, in_ready=0, then out_ready=1 -> IDLE next edge.
REQ-031 SHALL cover: reset=0 asserted 3 cycles into RUN -> all outputs reset asynchronously; next operands 0x12+0x34 -> s=0x46, cout=0.
REQ-032 SHALL cover: in_valid held 1 with changing a/b during RUN -> result reflects only first captured pair.
REQ-033 SHALL cover with SERIAL_ADDER_SUB_EN: a=0x05, b=0x07, sub=1 -> s=0xFE, cout=0; a=0x07, b=0x05, sub=1 -> s=0x02, cout=1.
